// File: rtl/mult_issue_ctrl.sv
// Multi-cycle front end for the registered signed 32x32 multiplier: issue, sign correction, half select.
// Optional last-result reuse enabled with `define MULT_OPERAND_CACHE_EN.
module mult_issue_ctrl #(
    parameter int TIMEOUT_CYCLES = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        flush,
    output logic        busy,
    output logic [31:0] result,
    output logic        result_valid,
    output logic        error,
    output logic [31:0] mult_a,
    output logic [31:0] mult_b,
    output logic        mult_start,
    input  logic [63:0] mult_y,
    input  logic        mult_done
);

    localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 2;
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_CORRECT,
        S_DONE,
        S_DRAIN
    } state_t;

    state_t state, state_nx;

    logic [31:0]   a_q, b_q;
    logic [1:0]    op_q;
    logic [63:0]   y_q;
    logic [CW-1:0] cnt;

    logic          ld_ops, ld_y, ld_res;
    logic [31:0]   res_nx;
    logic          set_valid, set_err;
    logic          cnt_clr, cnt_inc;
    logic          tmo;
    logic [63:0]   p_corr;

    function automatic logic [31:0] half_sel(input logic [63:0] p, input logic hi);
        return hi ? p[63:32] : p[31:0];
    endfunction

`ifdef MULT_OPERAND_CACHE_EN
    logic          c_v;
    logic [31:0]   c_a, c_b;
    logic          c_u;
    logic [63:0]   c_p;
    logic          hit;
    logic          cache_ld;
    logic [63:0]   cache_p_nx;

    assign hit = c_v && (a == c_a) && (b == c_b) && (op[0] == c_u);
`endif

    assign tmo = (cnt == TMO_LAST);

    // Signed product to unsigned product: add back the terms the sign bits subtracted.
    assign p_corr = y_q
                  + (a_q[31] ? {b_q, 32'h0} : 64'h0)
                  + (b_q[31] ? {a_q, 32'h0} : 64'h0);

    assign busy       = (state != S_IDLE);
    assign mult_a     = a_q;
    assign mult_b     = b_q;
    assign mult_start = (state == S_ISSUE) && !flush;

    always_comb begin
        state_nx  = state;
        ld_ops    = 1'b0;
        ld_y      = 1'b0;
        ld_res    = 1'b0;
        res_nx    = 32'h0;
        set_valid = 1'b0;
        set_err   = 1'b0;
        cnt_clr   = 1'b0;
        cnt_inc   = 1'b0;
`ifdef MULT_OPERAND_CACHE_EN
        cache_ld   = 1'b0;
        cache_p_nx = 64'h0;
`endif
        unique case (state)
            S_IDLE: begin
                if (req && !flush) begin
                    ld_ops   = 1'b1;
                    state_nx = S_ISSUE;
`ifdef MULT_OPERAND_CACHE_EN
                    if (hit) begin
                        state_nx  = S_DONE;
                        ld_res    = 1'b1;
                        res_nx    = half_sel(c_p, op[1]);
                        set_valid = 1'b1;
                    end
`endif
                end
            end
            S_ISSUE: begin
                if (flush) begin
                    state_nx = S_IDLE;
                end else begin
                    state_nx = S_WAIT;
                    cnt_clr  = 1'b1;
                end
            end
            S_WAIT: begin
                if (flush) begin
                    // A done arriving with the flush is already consumed.
                    state_nx = mult_done ? S_IDLE : S_DRAIN;
                    cnt_clr  = 1'b1;
                end else if (mult_done) begin
                    ld_y = 1'b1;
                    if (op_q[0]) begin
                        state_nx = S_CORRECT;
                    end else begin
                        state_nx  = S_DONE;
                        ld_res    = 1'b1;
                        res_nx    = half_sel(mult_y, op_q[1]);
                        set_valid = 1'b1;
`ifdef MULT_OPERAND_CACHE_EN
                        cache_ld   = 1'b1;
                        cache_p_nx = mult_y;
`endif
                    end
                end else if (tmo) begin
                    state_nx = S_DONE;
                    ld_res   = 1'b1;
                    res_nx   = 32'h0;
                    set_err  = 1'b1;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            S_CORRECT: begin
                if (flush) begin
                    state_nx = S_IDLE;
                end else begin
                    state_nx  = S_DONE;
                    ld_res    = 1'b1;
                    res_nx    = half_sel(p_corr, op_q[1]);
                    set_valid = 1'b1;
`ifdef MULT_OPERAND_CACHE_EN
                    cache_ld   = 1'b1;
                    cache_p_nx = p_corr;
`endif
                end
            end
            S_DONE: begin
                state_nx = S_IDLE;
            end
            S_DRAIN: begin
                if (mult_done || tmo) begin
                    state_nx = S_IDLE;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            a_q          <= 32'h0;
            b_q          <= 32'h0;
            op_q         <= 2'b00;
            y_q          <= 64'h0;
            cnt          <= '0;
            result       <= 32'h0;
            result_valid <= 1'b0;
            error        <= 1'b0;
        end else begin
            state        <= state_nx;
            result_valid <= set_valid;
            error        <= set_err;
            if (ld_ops) begin
                a_q  <= a;
                b_q  <= b;
                op_q <= op;
            end
            if (ld_y) begin
                y_q <= mult_y;
            end
            if (ld_res) begin
                result <= res_nx;
            end
            if (cnt_clr) begin
                cnt <= '0;
            end else if (cnt_inc) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

`ifdef MULT_OPERAND_CACHE_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            c_v <= 1'b0;
            c_a <= 32'h0;
            c_b <= 32'h0;
            c_u <= 1'b0;
            c_p <= 64'h0;
        end else if (flush || set_err) begin
            c_v <= 1'b0;
        end else if (cache_ld) begin
            c_v <= 1'b1;
            c_a <= a_q;
            c_b <= b_q;
            c_u <= op_q[0];
            c_p <= cache_p_nx;
        end
    end
`endif

endmodule

// File: tb/tb_mult_issue_ctrl.sv
// Scoreboard bench for mult_issue_ctrl with a behavioural multiplier and result model.
// Build with +define+MULT_OPERAND_CACHE_EN to also exercise result reuse.
module tb_mult_issue_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] a = 32'h0;
    logic [31:0] b = 32'h0;
    logic        flush = 1'b0;
    logic        busy;
    logic [31:0] result;
    logic        result_valid;
    logic        error;
    logic [31:0] mult_a;
    logic [31:0] mult_b;
    logic        mult_start;
    logic [63:0] mult_y = 64'h0;
    logic        mult_done = 1'b0;

    int checks = 0;
    int failures = 0;

    logic [32:0] exp_q[$];

    bit          c_v = 1'b0;
    logic [31:0] c_a = 32'h0;
    logic [31:0] c_b = 32'h0;
    logic        c_u = 1'b0;

    bit          stall_model = 1'b0;
    logic        s1_v = 1'b0;
    logic [63:0] s1_y = 64'h0;

    mult_issue_ctrl #(.TIMEOUT_CYCLES(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .req          (req),
        .op           (op),
        .a            (a),
        .b            (b),
        .flush        (flush),
        .busy         (busy),
        .result       (result),
        .result_valid (result_valid),
        .error        (error),
        .mult_a       (mult_a),
        .mult_b       (mult_b),
        .mult_start   (mult_start),
        .mult_y       (mult_y),
        .mult_done    (mult_done)
    );

    always #5 clk = ~clk;

    // Two-stage registered signed multiplier: start sampled at E1, done high E2..E3.
    always @(posedge clk) begin
        mult_done <= s1_v;
        mult_y    <= s1_v ? s1_y : 64'h0;
        s1_v      <= mult_start && !stall_model;
        s1_y      <= $signed({{32{mult_a[31]}}, mult_a}) * $signed({{32{mult_b[31]}}, mult_b});
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req_v);
        checks++;
        if (act !== req_v) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req_v);
        end
    endtask

    function automatic logic [31:0] ref_result(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        logic [63:0] p;
        longint sx, sy;
        if (o[0]) begin
            p = {32'h0, x} * {32'h0, y};
        end else begin
            sx = longint'($signed(x));
            sy = longint'($signed(y));
            p = 64'(sx * sy);
        end
        return o[1] ? p[63:32] : p[31:0];
    endfunction

    always @(negedge clk) begin
        logic [32:0] e;
        if (!reset && (result_valid || error)) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_output", {31'h0, error, result_valid}, 64'h0);
            end else begin
                e = exp_q.pop_front();
                if (e[32]) begin
                    chk("err_pulse", 64'(error), 64'h1);
                    chk("err_no_valid", 64'(result_valid), 64'h0);
                    chk("err_result", 64'(result), 64'h0);
                end else begin
                    chk("valid_pulse", 64'(result_valid), 64'h1);
                    chk("no_err", 64'(error), 64'h0);
                    chk("result", 64'(result), 64'(e[31:0]));
                end
            end
        end
    end

    task automatic do_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y, input bit stall);
        bit hit;
        bit to;
        int starts;
        int evt;
        int exp_lat;
        hit = 1'b0;
`ifdef MULT_OPERAND_CACHE_EN
        hit = c_v && (c_a == x) && (c_b == y) && (c_u == o[0]);
`endif
        to = stall && !hit;
        @(negedge clk);
        req = 1'b1;
        op = o;
        a = x;
        b = y;
        stall_model = to;
        @(posedge clk);
        #1;
        req = 1'b0;
        if (to) exp_q.push_back({1'b1, 32'h0});
        else exp_q.push_back({1'b0, ref_result(o, x, y)});
        starts = 0;
        evt = -1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (mult_start) starts++;
            if ((result_valid || error) && evt < 0) evt = k;
            if (!busy) break;
        end
        chk("idle_after_op", 64'(busy), 64'h0);
        exp_lat = hit ? 0 : (to ? 9 : (o[0] ? 4 : 3));
        chk("latency", 64'(evt), 64'(exp_lat));
        chk("start_count", 64'(starts), hit ? 64'h0 : 64'h1);
        if (to) begin
            c_v = 1'b0;
        end else begin
            c_v = 1'b1;
            c_a = x;
            c_b = y;
            c_u = o[0];
        end
        stall_model = 1'b0;
    endtask

    function automatic logic [31:0] pick();
        unique case ($urandom_range(0, 4))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return $urandom_range(0, 15);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog_expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ra, rb;
        logic [1:0] ro;
        ra = 32'h0;
        rb = 32'h0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'h0);
        chk("rst_result", 64'(result), 64'h0);
        chk("rst_valid", 64'(result_valid), 64'h0);
        chk("rst_error", 64'(error), 64'h0);
        chk("rst_start", 64'(mult_start), 64'h0);
        chk("rst_mult_a", 64'(mult_a), 64'h0);
        chk("rst_mult_b", 64'(mult_b), 64'h0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        do_op(2'b00, 32'hFFFF_FFFD, 32'd7, 1'b0);
        do_op(2'b10, 32'hFFFF_FFFD, 32'd7, 1'b0);
        do_op(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        do_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        do_op(2'b00, 32'd1234, 32'd5678, 1'b1);
        do_op(2'b00, 32'd3, 32'd5, 1'b0);

        // Flush while in ISSUE: no start, back to IDLE.
        @(negedge clk);
        req = 1'b1;
        op = 2'b00;
        a = 32'd5;
        b = 32'd9;
        @(posedge clk);
        #1;
        req = 1'b0;
        flush = 1'b1;
        @(negedge clk);
        chk("flush_issue_start", 64'(mult_start), 64'h0);
        chk("flush_issue_busy", 64'(busy), 64'h1);
        @(posedge clk);
        #1;
        flush = 1'b0;
        c_v = 1'b0;
        @(negedge clk);
        chk("flush_issue_idle", 64'(busy), 64'h0);

        // Flush while in WAIT: the late done is drained.
        @(negedge clk);
        req = 1'b1;
        op = 2'b01;
        a = 32'd11;
        b = 32'd13;
        @(posedge clk);
        #1;
        req = 1'b0;
        @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        c_v = 1'b0;
        @(negedge clk);
        chk("drain_busy", 64'(busy), 64'h1);
        @(negedge clk);
        chk("drain_exit", 64'(busy), 64'h0);
        do_op(2'b00, 32'd6, 32'd7, 1'b0);

        // Asynchronous reset in WAIT.
        @(negedge clk);
        req = 1'b1;
        op = 2'b01;
        a = 32'hDEAD_BEEF;
        b = 32'h1234_5678;
        @(posedge clk);
        #1;
        req = 1'b0;
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        chk("arst_busy", 64'(busy), 64'h0);
        chk("arst_result", 64'(result), 64'h0);
        chk("arst_start", 64'(mult_start), 64'h0);
        chk("arst_mult_a", 64'(mult_a), 64'h0);
        c_v = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (6) @(negedge clk);
        chk("arst_stays_idle", 64'(busy), 64'h0);

`ifdef MULT_OPERAND_CACHE_EN
        do_op(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        do_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        c_v = 1'b0;
        do_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
`endif

        for (int i = 0; i < 50; i++) begin
            ro = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 4) != 0) begin
                ra = pick();
                rb = pick();
            end
            do_op(ro, ra, rb, $urandom_range(0, 15) == 0);
        end

        repeat (4) @(negedge clk);
        chk("queue_drained", 64'(exp_q.size()), 64'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
